// File: rtl/spi_flash_cmd_engine_pkg.sv
// Shared definitions for the SPI flash command engine: FSM encodings,
// flash opcodes and the WBUF geometry.
package spi_flash_pkg;

  typedef logic [31:0] word_t;

  localparam int WBUF_DEPTH = 128;
  localparam int WBUF_AW    = 7;
  localparam int NBITS_W    = 12;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_SHIFT = 3'd1;
  localparam logic [2:0] ST_WR_END   = 3'd2;
  localparam logic [2:0] ST_RD_CMD   = 3'd3;
  localparam logic [2:0] ST_RD_DATA  = 3'd4;
  localparam logic [2:0] ST_RD_END   = 3'd5;

  localparam logic [7:0] OP_WRITE_ENABLE   = 8'h06;
  localparam logic [7:0] OP_WRITE_EXT_ADDR = 8'hC5;
  localparam logic [7:0] OP_READ           = 8'h03;

endpackage

// File: rtl/spi_flash_cmd_engine_if.sv
// Sequencer-side handshake, WBUF write port and SPI pins of the engine.
interface spi_flash_cmd_engine_if;
  import spi_flash_pkg::*;

  logic                          store_flash_command;
  logic [WBUF_AW-1:0]            wbuf_address;
  word_t                         flash_command;
  logic [NBITS_W-1:0]            flash_wr_nBits;
  logic                          send_write_command;
  logic                          read_bitstream;
  logic                          spi_miso;
  logic                          end_write_command;
  logic                          end_bitstream;
  logic                          bitstream;
  logic                          spi_cs_n;
  logic                          spi_mosi;
  logic                          spi_sck_en;

  modport master (
    output store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
    output send_write_command, read_bitstream, spi_miso,
    input  end_write_command, end_bitstream, bitstream,
    input  spi_cs_n, spi_mosi, spi_sck_en
  );

  modport slave (
    input  store_flash_command, wbuf_address, flash_command, flash_wr_nBits,
    input  send_write_command, read_bitstream, spi_miso,
    output end_write_command, end_bitstream, bitstream,
    output spi_cs_n, spi_mosi, spi_sck_en
  );

endinterface

// File: rtl/spi_flash_cmd_engine_wbuf_ram.sv
// 128x32 command buffer: one write port, one registered read port.
// A same-cycle write to the address being read is forwarded so a word
// stored just before a request is what gets shifted out.
module wbuf_ram
  import spi_flash_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [WBUF_AW-1:0] i_waddr,
  input  word_t              i_wdata,
  input  logic [WBUF_AW-1:0] i_raddr,
  output word_t              o_rdata
);

  word_t r_mem [0:WBUF_DEPTH-1];
  word_t r_rdata;

  // Memory write and registered read with write-first forwarding
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
    else                              r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_flash_cmd_engine.sv
// SPI master that serialises WBUF commands onto the configuration flash and
// streams the bitstream back one bit per clock. All pin outputs are
// registered and reflect the state held during the preceding cycle.
module spi_flash_cmd_engine #(
  parameter logic [31:0] RD_NBITS = 32'd17_536_096
) (
  input logic             clk,
  input logic             reset_n,
  spi_flash_cmd_engine_if.slave bus
);
  import spi_flash_pkg::*;

  logic [2:0]         r_state;
  logic [NBITS_W-1:0] r_bitidx;
  logic [NBITS_W-1:0] r_nbits;
  logic [31:0]        r_rdcnt;
  word_t              r_shreg;
  logic               r_mosi;
  logic               r_cs_n;
  logic               r_sck_en;
  logic               r_end_wr;
  logic               r_end_rd;
  logic               r_bitstream;

  logic               w_we;
  logic [WBUF_AW-1:0] w_raddr;
  word_t              w_rdata;
  logic               w_shifting;
  logic               w_boundary;
  logic               w_bit;

  assign w_we       = bus.store_flash_command && (r_state == ST_IDLE);
  assign w_shifting = (r_state == ST_WR_SHIFT) || (r_state == ST_RD_CMD);
  assign w_boundary = (r_bitidx[4:0] == 5'd0);
  // While shifting, the RAM already fetches the following word so it is
  // ready on the cycle the bit index crosses into it. Idle holds word 0.
  assign w_raddr    = w_shifting ? (r_bitidx[11:5] + 7'd1) : 7'd0;
  assign w_bit      = w_boundary ? w_rdata[31] : r_shreg[31];

  wbuf_ram u_wbuf (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (bus.wbuf_address),
    .i_wdata (bus.flash_command),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // FSM, counters and registered pin/handshake outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bitidx    <= '0;
      r_rdcnt     <= '0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sck_en    <= 1'b0;
      r_end_wr    <= 1'b0;
      r_end_rd    <= 1'b0;
      r_bitstream <= 1'b0;
    end else begin
      r_bitstream <= bus.spi_miso;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sck_en    <= 1'b0;
      r_end_wr    <= 1'b0;
      r_end_rd    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bitidx <= '0;
          if (bus.send_write_command)  r_state <= ST_WR_SHIFT;
          else if (bus.read_bitstream) r_state <= ST_RD_CMD;
        end
        ST_WR_SHIFT, ST_RD_CMD: begin
          r_mosi   <= w_bit;
          r_cs_n   <= 1'b0;
          r_sck_en <= 1'b1;
          r_bitidx <= r_bitidx + 12'd1;
          if (r_bitidx == r_nbits) begin
            r_rdcnt <= '0;
            r_state <= (r_state == ST_WR_SHIFT) ? ST_WR_END : ST_RD_DATA;
          end
        end
        ST_WR_END: begin
          r_end_wr <= 1'b1;
          if (!bus.send_write_command) r_state <= ST_IDLE;
        end
        ST_RD_DATA: begin
          r_cs_n   <= 1'b0;
          r_sck_en <= 1'b1;
          r_rdcnt  <= r_rdcnt + 32'd1;
          if (r_rdcnt == (RD_NBITS - 32'd1)) r_state <= ST_RD_END;
        end
        ST_RD_END: begin
          r_end_rd <= 1'b1;
          if (!bus.read_bitstream) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shift data path: bit count latched while idle, word shifted MSB-first
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE)
      r_nbits <= bus.send_write_command ? bus.flash_wr_nBits : 12'd31;
    if (w_shifting)
      r_shreg <= w_boundary ? {w_rdata[30:0], 1'b0} : {r_shreg[30:0], 1'b0};
  end

  assign bus.spi_mosi          = r_mosi;
  assign bus.spi_cs_n          = r_cs_n;
  assign bus.spi_sck_en        = r_sck_en;
  assign bus.end_write_command = r_end_wr;
  assign bus.end_bitstream     = r_end_rd;
  assign bus.bitstream         = r_bitstream;

endmodule
